// File: rtl/laser_pkg.sv
// Shared types and constants for the laser fire sequencer.
// Holds the FSM state encoding, the SPI frame bit positions used by the
// command and status paths, and a small helper for sizing counters.
package laser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_FIRE = 2'd2,
        ST_COOL = 2'd3
    } fire_state_e;

    // Position of the fire request in mosi_etc.
    localparam int MOSI_FIRE_FLAG_BIT = 13;
    // Position of laser_fire_complete in miso_etc.
    localparam int MISO_FIRE_DONE_BIT = 10;

    // Larger of two integers, used to size a counter shared by two phases.
    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single-bit level signal.
// Both flops clear on the asynchronous active-low reset so the synchronized
// output reads 0 until two clock edges after reset is released.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/laser_fire_sequencer.sv
// Laser fire sequencer: turns a rising SPI fire flag into one laser shot.
// IDLE -> ARM (wait for a sustained lock) -> FIRE (fixed dwell) -> COOL
// (fixed cooldown) -> IDLE. Lock status comes in through two synchronizers.
// Optional build macro FIRE_ABORT_EN: when defined, losing lock during FIRE
// cuts the laser at once, goes to a full COOL and flags abort; when not
// defined, FIRE always runs its full dwell.
module laser_fire_sequencer
    import laser_pkg::*;
#(
    parameter int ARM_CYCLES  = 250_000,
    parameter int ARM_TIMEOUT = 100_000_000,
    parameter int FIRE_CYCLES = 10_000_000,
    parameter int COOL_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mosi_valid,
    input  logic       fire_flag,
    input  logic       is_locked,
    input  logic       center_hit,
    output logic       laser_on,
    output logic       fire_complete,
    output logic       abort,
    output logic       busy,
    output logic [1:0] state,
    output logic [7:0] shot_count
);

    // Zero-length phases have no meaning; refuse to elaborate them.
    if (ARM_CYCLES < 1) begin : g_bad_arm
        $error("ARM_CYCLES must be at least 1");
    end
    if (ARM_TIMEOUT < 1) begin : g_bad_tmo
        $error("ARM_TIMEOUT must be at least 1");
    end
    if (FIRE_CYCLES < 1) begin : g_bad_fire
        $error("FIRE_CYCLES must be at least 1");
    end
    if (COOL_CYCLES < 1) begin : g_bad_cool
        $error("COOL_CYCLES must be at least 1");
    end

    // Each counter is wide enough to hold its terminal value plus one, so
    // the increment on the final cycle of a phase can never wrap.
    localparam int ARM_W   = $clog2(ARM_CYCLES + 1);
    localparam int TO_W    = $clog2(ARM_TIMEOUT + 1);
    localparam int DWELL_W = $clog2(max_i(FIRE_CYCLES, COOL_CYCLES) + 1);

    localparam logic [ARM_W-1:0]   ARM_LAST  = ARM_W'(ARM_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(ARM_TIMEOUT - 1);
    localparam logic [DWELL_W-1:0] FIRE_LAST = DWELL_W'(FIRE_CYCLES - 1);
    localparam logic [DWELL_W-1:0] COOL_LAST = DWELL_W'(COOL_CYCLES - 1);

    fire_state_e        state_q, state_d;
    logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    // FIRE and COOL never overlap, so one counter times both dwells.
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               flag_prev_q, flag_prev_d;
    logic               laser_on_q, laser_on_d;
    logic               fire_complete_q, fire_complete_d;
    logic               abort_q, abort_d;
    logic [7:0]         shot_count_q, shot_count_d;

    logic lock_s;
    logic hit_s;
    logic ok;
    logic cmd;
    logic arm_done;
    logic arm_tmo;
    logic fire_done;
    logic cool_done;

    bit_sync u_lock_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (is_locked),
        .q_o   (lock_s)
    );

    bit_sync u_hit_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (center_hit),
        .q_o   (hit_s)
    );

    // Target is usable only when both lock and center hit agree.
    assign ok  = lock_s & hit_s;
    // A command is a rising fire flag between consecutive valid frames.
    assign cmd = mosi_valid & fire_flag & ~flag_prev_q;

    assign arm_done  = ok && (arm_cnt_q == ARM_LAST);
    assign arm_tmo   = (to_cnt_q == TO_LAST);
    assign fire_done = (dwell_cnt_q == FIRE_LAST);
    assign cool_done = (dwell_cnt_q == COOL_LAST);

    // State and datapath registers; reset drops the laser immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            arm_cnt_q       <= '0;
            to_cnt_q        <= '0;
            dwell_cnt_q     <= '0;
            flag_prev_q     <= 1'b0;
            laser_on_q      <= 1'b0;
            fire_complete_q <= 1'b0;
            abort_q         <= 1'b0;
            shot_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            arm_cnt_q       <= arm_cnt_d;
            to_cnt_q        <= to_cnt_d;
            dwell_cnt_q     <= dwell_cnt_d;
            flag_prev_q     <= flag_prev_d;
            laser_on_q      <= laser_on_d;
            fire_complete_q <= fire_complete_d;
            abort_q         <= abort_d;
            shot_count_q    <= shot_count_d;
        end
    end

    // Next-state selection; arming wins over a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (arm_done) begin
                    state_d = ST_FIRE;
                end else if (arm_tmo) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRE: begin
`ifdef FIRE_ABORT_EN
                if (!ok || fire_done) begin
                    state_d = ST_COOL;
                end
`else
                if (fire_done) begin
                    state_d = ST_COOL;
                end
`endif
            end
            ST_COOL: begin
                if (cool_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter and registered-output updates that accompany each state.
    always_comb begin
        arm_cnt_d       = arm_cnt_q;
        to_cnt_d        = to_cnt_q;
        dwell_cnt_d     = dwell_cnt_q;
        laser_on_d      = laser_on_q;
        fire_complete_d = fire_complete_q;
        abort_d         = abort_q;
        shot_count_d    = shot_count_q;
        // Edge history follows every frame, whatever the state, so a held
        // flag never produces a second command.
        flag_prev_d     = mosi_valid ? fire_flag : flag_prev_q;

        unique case (state_q)
            ST_IDLE: begin
                arm_cnt_d   = '0;
                to_cnt_d    = '0;
                dwell_cnt_d = '0;
                if (cmd) begin
                    fire_complete_d = 1'b0;
                    abort_d         = 1'b0;
                end
            end
            ST_ARM: begin
                to_cnt_d  = to_cnt_q + TO_W'(1);
                arm_cnt_d = ok ? (arm_cnt_q + ARM_W'(1)) : '0;
                if (arm_done) begin
                    laser_on_d   = 1'b1;
                    shot_count_d = shot_count_q + 8'd1;
                    dwell_cnt_d  = '0;
                end else if (arm_tmo) begin
                    abort_d = 1'b1;
                end
            end
            ST_FIRE: begin
                dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
`ifdef FIRE_ABORT_EN
                if (!ok) begin
                    laser_on_d  = 1'b0;
                    abort_d     = 1'b1;
                    dwell_cnt_d = '0;
                end else if (fire_done) begin
                    laser_on_d      = 1'b0;
                    fire_complete_d = 1'b1;
                    dwell_cnt_d     = '0;
                end
`else
                if (fire_done) begin
                    laser_on_d      = 1'b0;
                    fire_complete_d = 1'b1;
                    dwell_cnt_d     = '0;
                end
`endif
            end
            ST_COOL: begin
                dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                if (cool_done) begin
                    dwell_cnt_d = '0;
                end
            end
            default: begin
                laser_on_d = 1'b0;
            end
        endcase
    end

    // Port drive from the registered state.
    always_comb begin
        laser_on      = laser_on_q;
        fire_complete = fire_complete_q;
        abort         = abort_q;
        busy          = (state_q != ST_IDLE);
        state         = state_q;
        shot_count    = shot_count_q;
    end

endmodule

// File: tb/tb_laser_fire_sequencer.sv
// Directed testbench for laser_fire_sequencer with short phase lengths.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_laser_fire_sequencer;

    localparam int ARM_C  = 4;
    localparam int TMO_C  = 20;
    localparam int FIRE_C = 8;
    localparam int COOL_C = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_FIRE = 2'd2;
    localparam logic [1:0] S_COOL = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mosi_valid = 1'b0;
    logic       fire_flag = 1'b0;
    logic       is_locked = 1'b0;
    logic       center_hit = 1'b0;
    logic       laser_on;
    logic       fire_complete;
    logic       abort;
    logic       busy;
    logic [1:0] state;
    logic [7:0] shot_count;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    laser_fire_sequencer #(
        .ARM_CYCLES  (ARM_C),
        .ARM_TIMEOUT (TMO_C),
        .FIRE_CYCLES (FIRE_C),
        .COOL_CYCLES (COOL_C)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mosi_valid    (mosi_valid),
        .fire_flag     (fire_flag),
        .is_locked     (is_locked),
        .center_hit    (center_hit),
        .laser_on      (laser_on),
        .fire_complete (fire_complete),
        .abort         (abort),
        .busy          (busy),
        .state         (state),
        .shot_count    (shot_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle valid frame; returns on the falling edge after it was taken.
    task automatic send_frame(input logic f);
        mosi_valid = 1'b1;
        fire_flag  = f;
        @(negedge clk);
        mosi_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b0;
        #10;
        check("rst_laser", laser_on, 0);
        check("rst_state", state, S_IDLE);
        check("rst_busy", busy, 0);
        check("rst_shots", shot_count, 0);
        check("rst_done", fire_complete, 0);
        check("rst_abort", abort, 0);
        @(negedge clk);
        reset = 1'b1;
        is_locked  = 1'b1;
        center_hit = 1'b1;
        wait_n(3);

        // 1: basic shot timing
        send_frame(1'b1);
        check("t1_arm", state, S_ARM);
        check("t1_busy", busy, 1);
        for (int k = 1; k <= 12; k++) begin
            wait_n(1);
            check("t1_laser", laser_on, (k >= 4 && k <= 11) ? 1 : 0);
        end
        check("t1_cool", state, S_COOL);
        check("t1_done", fire_complete, 1);
        check("t1_shots", shot_count, 1);
        wait_n(5);
        check("t1_cool_end", state, S_COOL);
        wait_n(1);
        check("t1_idle", state, S_IDLE);
        check("t1_done_sticky", fire_complete, 1);
        check("t1_not_busy", busy, 0);

        // 2: a one-cycle hit dropout restarts arming
        send_frame(1'b0);
        send_frame(1'b1);
        check("t2_arm", state, S_ARM);
        check("t2_done_clr", fire_complete, 0);
        wait_n(1);
        center_hit = 1'b0;
        wait_n(1);
        center_hit = 1'b1;
        for (int k = 3; k <= 8; k++) begin
            wait_n(1);
            check("t2_laser", laser_on, (k == 8) ? 1 : 0);
        end
        check("t2_fire", state, S_FIRE);
        check("t2_shots", shot_count, 2);
        wait_n(13);
        check("t2_cool", state, S_COOL);
        wait_n(1);
        check("t2_idle", state, S_IDLE);
        check("t2_done", fire_complete, 1);

        // 3: no lock -> arm timeout
        send_frame(1'b0);
        is_locked = 1'b0;
        wait_n(3);
        send_frame(1'b1);
        check("t3_arm", state, S_ARM);
        for (int k = 1; k <= 19; k++) begin
            wait_n(1);
            check("t3_laser", laser_on, 0);
        end
        check("t3_still_arm", state, S_ARM);
        wait_n(1);
        check("t3_idle", state, S_IDLE);
        check("t3_abort", abort, 1);
        check("t3_laser_end", laser_on, 0);
        check("t3_shots", shot_count, 2);
        check("t3_done", fire_complete, 0);

        // 4: held flag gives exactly one shot
        is_locked = 1'b1;
        wait_n(3);
        send_frame(1'b0);
        send_frame(1'b1);
        check("t4_arm", state, S_ARM);
        check("t4_abort_clr", abort, 0);
        wait_n(4);
        check("t4_laser", laser_on, 1);
        wait_n(1);
        send_frame(1'b1);
        check("t4_fire", state, S_FIRE);
        wait_n(7);
        send_frame(1'b1);
        check("t4_cool", state, S_COOL);
        wait_n(4);
        check("t4_idle", state, S_IDLE);
        send_frame(1'b1);
        check("t4_idle_f1", state, S_IDLE);
        send_frame(1'b1);
        check("t4_idle_f2", state, S_IDLE);
        check("t4_shots", shot_count, 3);
        send_frame(1'b0);
        send_frame(1'b1);
        check("t4_arm2", state, S_ARM);
        wait_n(4);
        check("t4_laser2", laser_on, 1);
        check("t4_shots2", shot_count, 4);
        wait_n(9);
        check("t4_cool2", state, S_COOL);
        check("t4_done2", fire_complete, 1);
        send_frame(1'b0);
        wait_n(3);
        check("t4_cool2_end", state, S_COOL);
        // rising flag taken on the COOL->IDLE edge must be ignored
        send_frame(1'b1);
        check("t4_edge_idle", state, S_IDLE);
        wait_n(1);
        check("t4_edge_stay", state, S_IDLE);
        check("t4_edge_busy", busy, 0);

        // 5: lock lost in the third FIRE cycle
        send_frame(1'b0);
        send_frame(1'b1);
        check("t5_arm", state, S_ARM);
        wait_n(6);
        check("t5_laser", laser_on, 1);
        is_locked = 1'b0;
        wait_n(2);
        check("t5_laser_lag", laser_on, 1);
        wait_n(1);
`ifdef FIRE_ABORT_EN
        check("t5_laser_off", laser_on, 0);
        check("t5_cool", state, S_COOL);
        check("t5_abort", abort, 1);
        check("t5_done", fire_complete, 0);
        wait_n(5);
        check("t5_cool_end", state, S_COOL);
        wait_n(1);
        check("t5_idle", state, S_IDLE);
        check("t5_abort_sticky", abort, 1);
        check("t5_done_idle", fire_complete, 0);
`else
        check("t5_laser_hold", laser_on, 1);
        wait_n(2);
        check("t5_laser_last", laser_on, 1);
        wait_n(1);
        check("t5_laser_off", laser_on, 0);
        check("t5_cool", state, S_COOL);
        check("t5_done", fire_complete, 1);
        check("t5_abort", abort, 0);
        wait_n(6);
        check("t5_idle", state, S_IDLE);
`endif
        check("t5_shots", shot_count, 5);
        is_locked = 1'b1;

        // 6: asynchronous reset in the middle of FIRE
        wait_n(3);
        send_frame(1'b0);
        send_frame(1'b1);
        check("t6_arm", state, S_ARM);
        wait_n(6);
        check("t6_laser", laser_on, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_laser", laser_on, 0);
        check("t6_rst_state", state, S_IDLE);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_shots", shot_count, 0);
        check("t6_rst_done", fire_complete, 0);
        check("t6_rst_abort", abort, 0);
        @(negedge clk);
        check("t6_rst_hold", laser_on, 0);
        reset = 1'b1;
        wait_n(3);
        send_frame(1'b1);
        check("t6_arm2", state, S_ARM);
        wait_n(4);
        check("t6_laser2", laser_on, 1);
        check("t6_shots", shot_count, 1);
        wait_n(8);
        check("t6_laser2_off", laser_on, 0);
        check("t6_done", fire_complete, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
